// File: rtl/einsum_reduce_ctrl.sv
// Streaming log-sum-exp reduction controller driving an external einsum_add.
// Optional NEG_INF skipping in ACCUM: define EINSUM_REDUCE_SKIP_NEG_INF_EN.
module einsum_reduce_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_LEN    = 1024,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [1:0]            in_mode,
    output logic [WORD_WIDTH-1:0] add_operand_a,
    output logic [WORD_WIDTH-1:0] add_operand_b,
    output logic                  add_enable,
    output logic                  add_bypass,
    output logic [1:0]            add_pe_mode,
    input  logic [WORD_WIDTH-1:0] add_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [WORD_WIDTH-1:0] NEG_INF = WORD_WIDTH'(32'h0080_0000);
    localparam logic                  ONE_MAX = (MAX_LEN == 1);

    state_t               state;
    logic [1:0]           mode_q;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 acc;
    logic                 first;
    logic                 at_max;
    logic                 skip;

    assign in_ready = !rst && (state == IDLE || state == ACCUM);
    assign acc      = in_valid && in_ready;
    assign first    = (state == IDLE);
    assign cnt_nxt  = count + CNT_WIDTH'(1);
    assign at_max   = (cnt_nxt == CNT_WIDTH'(MAX_LEN));

`ifdef EINSUM_REDUCE_SKIP_NEG_INF_EN
    // A NEG_INF term leaves the running sum unchanged, so the adder is not used.
    assign skip = !first && mode_q == 2'b00 && in_data == NEG_INF;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        add_operand_a = '0;
        add_operand_b = '0;
        add_enable    = 1'b0;
        add_bypass    = 1'b0;
        add_pe_mode   = 2'b00;
        if (acc) begin
            if (first) begin
                add_operand_a = in_data;
                add_bypass    = 1'b1;
                add_enable    = 1'b1;
                add_pe_mode   = in_mode;
            end else if (!skip) begin
                add_operand_a = add_sum;
                add_operand_b = in_data;
                add_enable    = 1'b1;
                add_pe_mode   = mode_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode_q       <= 2'b00;
            count        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        mode_q <= in_mode;
                        count  <= CNT_WIDTH'(1);
                        if (in_last || ONE_MAX) begin
                            state        <= DRAIN;
                            out_overflow <= !in_last && ONE_MAX;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        count <= cnt_nxt;
                        if (in_last || at_max) begin
                            state        <= DRAIN;
                            out_overflow <= !in_last && at_max;
                        end
                    end
                end
                DRAIN: begin
                    // Adder output now reflects the final accepted element.
                    out_data  <= add_sum;
                    out_count <= count;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid    <= 1'b0;
                        out_overflow <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_einsum_reduce_ctrl.sv
// Self-checking bench for einsum_reduce_ctrl with a stand-in adder
// and a transaction-level reduction model.
module tb_einsum_reduce_ctrl;

    localparam int W    = 32;
    localparam int MAXL = 4;
    localparam int CW   = 3;
    localparam logic [31:0] NEG = 32'h0080_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [1:0]    in_mode = 2'b00;
    logic [W-1:0]  add_operand_a;
    logic [W-1:0]  add_operand_b;
    logic          add_enable;
    logic          add_bypass;
    logic [1:0]    add_pe_mode;
    logic [W-1:0]  add_sum = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    einsum_reduce_ctrl #(
        .WORD_WIDTH(W),
        .MAX_LEN(MAXL),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .in_mode(in_mode),
        .add_operand_a(add_operand_a),
        .add_operand_b(add_operand_b),
        .add_enable(add_enable),
        .add_bypass(add_bypass),
        .add_pe_mode(add_pe_mode),
        .add_sum(add_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_count(out_count),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Stand-in combine: larger operand plus 1/16 of the smaller.
    function automatic logic [31:0] lse(input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] hi, lo;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        return hi + (lo >> 4);
    endfunction

    always @(posedge clk) begin
        if (rst)
            add_sum <= '0;
        else if (add_enable)
            add_sum <= add_bypass ? add_operand_a : lse(add_operand_a, add_operand_b);
    end

    // Reduction model: fold of accepted words, result due 2 edges after the end.
    bit          started = 0;
    bit          in_rst  = 0;
    bit          busy    = 0;
    bit          active  = 0;
    int          since   = 0;
    logic [31:0] m_acc   = '0;
    int          m_cnt   = 0;
    logic [1:0]  m_mode  = 2'b00;
    logic [31:0] r_data  = '0;
    int          r_cnt   = 0;
    bit          r_ovf   = 0;

    function automatic bit skip_elem(input logic [31:0] d);
`ifdef EINSUM_REDUCE_SKIP_NEG_INF_EN
        return active && m_mode == 2'b00 && d == NEG;
`else
        return (d == NEG) && 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            in_rst = 1;
            busy   = 0;
            active = 0;
            since  = 0;
        end else begin
            in_rst = 0;
            if (busy) begin
                if (since >= 2 && out_ready) busy = 0;
                else since++;
            end else if (in_valid) begin
                if (!active) begin
                    m_acc  = in_data;
                    m_cnt  = 1;
                    m_mode = in_mode;
                    active = 1;
                end else begin
                    if (!skip_elem(in_data)) m_acc = lse(m_acc, in_data);
                    m_cnt++;
                end
                if (in_last || m_cnt == MAXL) begin
                    r_data = m_acc;
                    r_cnt  = m_cnt;
                    r_ovf  = !in_last;
                    busy   = 1;
                    since  = 0;
                    active = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit exp_ready, exp_valid, accept, exp_en;
        if (started) begin
            exp_ready = !rst && !busy;
            accept    = in_valid && exp_ready;
            exp_en    = accept && !skip_elem(in_data);
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (in_rst) begin
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_data", out_data, 32'd0);
                chk("rst_out_count", 32'(out_count), 32'd0);
                chk("rst_out_overflow", 32'(out_overflow), 32'd0);
            end else begin
                exp_valid = busy && since >= 2;
                chk("out_valid", 32'(out_valid), 32'(exp_valid));
                if (exp_valid) begin
                    chk("out_data", out_data, r_data);
                    chk("out_count", 32'(out_count), 32'(r_cnt));
                    chk("out_overflow", 32'(out_overflow), 32'(r_ovf));
                end
            end
            chk("add_enable", 32'(add_enable), 32'(exp_en));
            chk("add_bypass", 32'(add_bypass), 32'(accept && !active));
            if (exp_en && !active) begin
                chk("load_opa", add_operand_a, in_data);
                chk("load_opb", add_operand_b, 32'd0);
                chk("load_mode", 32'(add_pe_mode), 32'(in_mode));
            end else if (exp_en) begin
                chk("acc_opa", add_operand_a, m_acc);
                chk("acc_opb", add_operand_b, in_data);
                chk("acc_mode", 32'(add_pe_mode), 32'(m_mode));
            end else begin
                chk("idle_opa", add_operand_a, 32'd0);
                chk("idle_opb", add_operand_b, 32'd0);
                chk("idle_mode", 32'(add_pe_mode), 32'd0);
            end
        end
    end

    bit rdy_rand = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] d, input bit last,
                        input logic [1:0] mode, output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_mode  = mode;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) fail_timeout("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(output logic [31:0] d, output int cnt,
                              output bit ovf, output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 200) fail_timeout("get_result");
        d   = out_data;
        cnt = int'(out_count);
        ovf = out_overflow;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string name, input logic [31:0] d,
                                 input int cnt, input bit ovf);
        logic [31:0] rd;
        int rc, lat;
        bit ro;
        get_result(rd, rc, ro, lat);
        chk({name, "_data"}, rd, d);
        chk({name, "_count"}, 32'(rc), 32'(cnt));
        chk({name, "_ovf"}, 32'(ro), 32'(ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, lat, rc, len, n;
        logic [31:0] rd, d;
        bit ro;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        send(32'hCAFEBABE, 1, 2'b01, w);
        get_result(rd, rc, ro, lat);
        chk("single_data", rd, 32'hCAFEBABE);
        chk("single_count", 32'(rc), 32'd1);
        chk("single_latency", 32'(lat), 32'd2);

        send(32'h0010_0000, 0, 2'b00, w);
        send(32'h0020_0000, 1, 2'b00, w);
        expect_result("pair", 32'h0021_0000, 2, 0);

        send(32'h0010_0000, 0, 2'b00, w);
        send(32'h0008_0000, 0, 2'b00, w);
        chk("b2b_wait", 32'(w), 32'd0);
        send(32'h0020_0000, 1, 2'b11, w);
        chk("b2b_wait", 32'(w), 32'd0);
        expect_result("three", 32'h0021_0800, 3, 0);

        out_ready = 1'b0;
        send(32'h1111_1111, 1, 2'b00, w);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", out_data, 32'h1111_1111);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        get_result(rd, rc, ro, lat);
        send(32'h0000_0022, 1, 2'b00, w);
        chk("turnaround_wait", 32'(w), 32'd0);
        expect_result("after_bp", 32'h0000_0022, 1, 0);

        for (int i = 1; i <= 4; i++) begin
            d = 32'(i) << 20;
            send(d, 0, 2'b00, w);
        end
        expect_result("overflow", 32'h0043_2100, 4, 1);
        send(32'h0050_0000, 0, 2'b00, w);
        send(32'h0060_0000, 0, 2'b00, w);
        send(32'h0070_0000, 1, 2'b00, w);
        expect_result("post_ovf", 32'h0076_5000, 3, 0);

        for (int i = 0; i < 4; i++) send(32'h10, i == 3, 2'b00, w);
        expect_result("last_at_max", 32'h13, 4, 0);

`ifdef EINSUM_REDUCE_SKIP_NEG_INF_EN
        send(32'h0012_3456, 0, 2'b00, w);
        send(NEG, 1, 2'b00, w);
        expect_result("skip_neg_inf", 32'h0012_3456, 2, 0);
`endif

        send(32'h0030_0000, 0, 2'b00, w);
        send(32'h0040_0000, 0, 2'b00, w);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_no_out", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        rdy_rand = 1;
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++) begin
                n = $urandom_range(0, 3);
                repeat (n == 3 ? 1 : 0) begin
                    @(posedge clk);
                    #1;
                end
                d = ($urandom_range(0, 7) == 0) ? NEG : $urandom;
                send(d, e == len - 1, 2'($urandom_range(0, 3)), w);
            end
        end
        rdy_rand = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
        end
        if (busy) fail_timeout("final_drain");
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/einsum_reduce_ctrl.md
# einsum_reduce_ctrl

Streaming log-domain reduction controller that sits directly upstream of `einsum_add` and also consumes its `sum_out`. It accepts a valid/ready stream of log-domain words terminated by `in_last` and drives `einsum_add` to compute a running log-sum-exp. On the first element it loads the accumulator through the adder's bypass path. After the last element it presents one reduced word on a valid/ready output port.

## Interface
Parameters:
- `WORD_WIDTH`, 32, data width; matches `einsum_add`.
- `MAX_LEN`, 1024, maximum elements per reduction before forced termination.
- `CNT_WIDTH`, 11, width of the element counter; must hold `MAX_LEN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: controller accepts an element this cycle.
- `in_data` in `WORD_WIDTH`: log-domain element.
- `in_last` in 1: final element of the current reduction.
- `in_mode` in 2: `pe_mode` for the reduction, sampled with the first element.
- `add_operand_a` out `WORD_WIDTH`: to `einsum_add.operand_a`.
- `add_operand_b` out `WORD_WIDTH`: to `einsum_add.operand_b`.
- `add_enable` out 1: to `einsum_add.enable`.
- `add_bypass` out 1: to `einsum_add.bypass`.
- `add_pe_mode` out 2: to `einsum_add.pe_mode`.
- `add_sum` in `WORD_WIDTH`: from `einsum_add.sum_out`, registered with 1-cycle latency.
- `out_valid` out 1: reduced result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out `WORD_WIDTH`: reduced log-sum-exp.
- `out_count` out `CNT_WIDTH`: number of elements consumed.
- `out_overflow` out 1: reduction was force-terminated at `MAX_LEN`.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
- Accept event `acc = in_valid && in_ready`.
- `in_ready` is 1 in IDLE and ACCUM, and 0 in DRAIN and HOLD.
- IDLE behaviour:
  - On `acc`, drive `add_operand_a=in_data`, `add_bypass=1`, `add_enable=1`, `add_pe_mode=in_mode`, `add_operand_b=0`.
  - Latch `in_mode` and set count=1.
  - Go to DRAIN if `in_last`, otherwise ACCUM.
- ACCUM behaviour:
  - On `acc`, drive `add_operand_a=add_sum`, `add_operand_b=in_data`, `add_bypass=0`, `add_enable=1`, `add_pe_mode=latched mode`.
  - count+1.
  - Go to DRAIN if `in_last`, or if count+1 == `MAX_LEN`. In the `MAX_LEN` case, set `out_overflow=1`.
- No accept event (any state): `add_enable=0`, `add_bypass=0`, operands 0; the adder holds its output.
- DRAIN: one cycle. Register `add_sum` into `out_data` and count into `out_count`, then go to HOLD.
- HOLD: `out_valid=1`, outputs stable. On `out_ready`, go to IDLE and clear `out_overflow`.
- Back-to-back elements are accepted every cycle in ACCUM. The feedback `add_operand_a=add_sum` is combinational from the adder's registered output.
- A change of `in_mode` mid-reduction is ignored.
- `in_data` is not interpreted, except under the configuration macro.
- Reset:
  - All outputs 0: `in_ready=0` while `rst` is high, `out_valid=0`, `out_data=0`, `out_count=0`, `out_overflow=0`, `add_*=0`.
  - State goes to IDLE.
  - Reset mid-reduction discards the partial result with no output.

## Timing
- A single-element reduction accepted at edge N gives `out_valid=1` after edge N+2.
- For an L-element stream without stalls, the first element is accepted at edge N and the last at edge N+L-1. `out_valid` rises after edge N+L+1.
- Minimum turnaround is one cycle after the output handshake: IDLE re-accepts the cycle after the edge where `out_valid && out_ready`.
- `in_valid` low gaps in ACCUM stall with no state change.
- `in_last` with overflow on the same element: `out_overflow=0`, because termination is legal.

## Configuration
- Macro: `EINSUM_REDUCE_SKIP_NEG_INF_EN`.
- Defined:
  - In ACCUM, an accepted element equal to NEG_INF (`0x00800000` in mode `2'b00`) is consumed with `add_enable=0`.
  - Count still increments and `in_last` still terminates.
  - In IDLE, a NEG_INF first element is still loaded via bypass.
- Undefined: every element is issued to the adder.

## Test plan
- Single element: `0xCAFEBABE` with `in_last=1` -> `out_data=0xCAFEBABE`, `out_count=1`, `out_valid` two edges after accept.
- Pair: `0x00100000` then `0x00200000` (last), mode 00 -> `out_data=0x00210000`, `out_count=2`, `add_bypass` high only on the first beat.
- Three beats back-to-back: `0x00100000`, `0x00080000`, `0x00200000` (last) -> `in_ready` held 1 for 3 cycles, then 0 until the output handshake; result matches the `einsum_add` chain.
- Backpressure: hold `out_ready=0` for 5 cycles -> `out_data` stable and `in_ready=0`; release -> IDLE, next stream accepted the following cycle.
- Overflow with `MAX_LEN=4`: 6 elements, no `in_last` -> terminates after 4, `out_count=4`, `out_overflow=1`; the 5th element starts a new reduction.
- Reset mid-ACCUM after 2 elements -> no `out_valid`, all outputs 0. With the macro defined, `0x00123456`, `0x00800000` (last) -> `add_enable=0` on beat 2, `out_data=0x00123456`.
